// File: rtl/am2932_pcu_pkg.sv
// Instruction codes shared by the program control unit and its stack.
package am2932_pcu_pkg;

    localparam logic [3:0] PRST = 4'b0000;  // reset pc, sp and sticky flags
    localparam logic [3:0] PSUS = 4'b0001;  // suspend: y floats, state held
    localparam logic [3:0] PSHD = 4'b0010;  // push d
    localparam logic [3:0] POPS = 4'b0011;  // pop stack onto y
    localparam logic [3:0] FPC  = 4'b0100;  // fetch pc
    localparam logic [3:0] JMPD = 4'b0101;  // jump to d
    localparam logic [3:0] PSHP = 4'b0110;  // push pc
    localparam logic [3:0] RTS  = 4'b0111;  // return from subroutine
    localparam logic [3:0] FR   = 4'b1000;  // fetch r
    localparam logic [3:0] FPR  = 4'b1001;  // fetch pc+r
    localparam logic [3:0] FPLR = 4'b1010;  // fetch pc, load r with pc
    localparam logic [3:0] JMPR = 4'b1011;  // jump to r
    localparam logic [3:0] JPPR = 4'b1100;  // jump to pc+r
    localparam logic [3:0] JSBR = 4'b1101;  // call r
    localparam logic [3:0] JSPR = 4'b1110;  // call pc+r
    localparam logic [3:0] PLDR = 4'b1111;  // fetch pc, load r with d

endpackage

// File: rtl/am2932_pcu_stack.sv
// LIFO address stack with pointer, full/empty status and sticky
// overflow/underflow flags. A push onto a full stack and a pop from an
// empty stack leave the pointer alone and only raise the sticky flag.
module am2932_pcu_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 17,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf
);

    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    logic [WIDTH-1:0] stk [DEPTH];

    assign full  = (sp == SP_MAX);
    assign empty = (sp == '0);

    // Top of stack; an empty stack presents word 0.
    always_comb begin
        top = stk[0];
        if (!empty) top = stk[sp - 1'b1];
    end

    // Stack words carry no reset; they are written only by an accepted push.
    always_ff @(posedge clk) begin
        if (rst_ && !clr && push && !full) stk[sp] <= push_data;
    end

    // Pointer and sticky flags; reset and clear win over push/pop.
    always_ff @(posedge clk) begin
        if (!rst_ || clr) begin
            sp  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (push) begin
            if (full) ovf <= 1'b1;
            else      sp  <= sp + 1'b1;
        end else if (pop) begin
            if (empty) udf <= 1'b1;
            else       sp  <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/am2932_pcu.sv
// Program control unit: selects the next address from pc, r, d, pc+r or
// the stack top, and updates pc/r/stack per the 4-bit instruction.
// No handshakes: every instruction takes effect at the next cp rise.
module am2932_pcu
    import am2932_pcu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 17,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             cp,
    input  logic             rst_,
    input  logic [3:0]       i,
    input  logic [WIDTH-1:0] d,
    input  logic             oe_,
    input  logic             cn,
    input  logic             ci,
    output logic [WIDTH-1:0] y,
    output logic             cn4,
    output logic             ci4,
    output logic             full_,
    output logic             empty_,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] pc, r;
    logic [WIDTH-1:0] pc_nxt, r_nxt, push_data, yint, sum, inc, top;
    logic [WIDTH:0]   sum_full, inc_full;
    logic [SPW-1:0]   sp;
    logic             push, pop, clr, ld_r, yen, full, empty;

    // Adder and incrementer with carries kept live even when y floats.
    assign sum_full = {1'b0, pc} + {1'b0, r} + {{WIDTH{1'b0}}, cn};
    assign sum      = sum_full[WIDTH-1:0];
    assign cn4      = sum_full[WIDTH];
    assign inc_full = {1'b0, yint} + {{WIDTH{1'b0}}, ci};
    assign inc      = inc_full[WIDTH-1:0];
    assign ci4      = inc_full[WIDTH];

    assign yen    = !oe_ && (i != PSUS);
    assign y      = yen ? yint : {WIDTH{1'bz}};
    assign full_  = !full;
    assign empty_ = !empty;

    // Instruction decode: source select, pc/r next values, stack controls.
    // Jumps load pc with selected source plus ci, which is exactly inc.
    always_comb begin
        yint      = pc;
        pc_nxt    = pc + {{(WIDTH-1){1'b0}}, ci};
        r_nxt     = d;
        ld_r      = 1'b0;
        push      = 1'b0;
        push_data = pc;
        pop       = 1'b0;
        clr       = 1'b0;
        case (i)
            PRST: begin yint = '0; pc_nxt = '0; clr = 1'b1; end
            PSUS: pc_nxt = pc;
            PSHD: begin push = 1'b1; push_data = d; end
            POPS: begin yint = top; pop = 1'b1; end
            FPC:  ;
            JMPD: begin yint = d; pc_nxt = inc; end
            PSHP: push = 1'b1;
            RTS:  begin yint = top; pop = 1'b1; pc_nxt = inc; end
            FR:   yint = r;
            FPR:  yint = sum;
            FPLR: begin ld_r = 1'b1; r_nxt = pc; end
            JMPR: begin yint = r; pc_nxt = inc; end
            JPPR: begin yint = sum; pc_nxt = inc; end
            JSBR: begin yint = r; push = 1'b1; pc_nxt = inc; end
            JSPR: begin yint = sum; push = 1'b1; pc_nxt = inc; end
            PLDR: ld_r = 1'b1;
            default: ;
        endcase
    end

    // Program counter: cleared by reset, otherwise follows decode.
    always_ff @(posedge cp) begin
        if (!rst_) pc <= '0;
        else       pc <= pc_nxt;
    end

    // Auxiliary register has no reset, but reset still blocks its load.
    always_ff @(posedge cp) begin
        if (rst_ && ld_r) r <= r_nxt;
    end

    am2932_pcu_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk       (cp),
        .rst_      (rst_),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (top),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .udf       (udf)
    );

endmodule

// File: tb/tb_am2932_pcu.sv
// Directed bench for am2932_pcu (WIDTH=4, DEPTH=17) with hand-computed
// expected values checked by immediate assertions.
module tb_am2932_pcu;
    import am2932_pcu_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 17;

    logic             cp;
    logic             rst_;
    logic [3:0]       i;
    logic [WIDTH-1:0] d;
    logic             oe_;
    logic             cn;
    logic             ci;
    wire  [WIDTH-1:0] y;
    logic             cn4, ci4, full_, empty_, ovf, udf;

    int n_cmp = 0;
    int n_bad = 0;

    am2932_pcu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .cp     (cp),
        .rst_   (rst_),
        .i      (i),
        .d      (d),
        .oe_    (oe_),
        .cn     (cn),
        .ci     (ci),
        .y      (y),
        .cn4    (cn4),
        .ci4    (ci4),
        .full_  (full_),
        .empty_ (empty_),
        .ovf    (ovf),
        .udf    (udf)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ii, input logic [3:0] dd,
                         input logic cc, input logic nn);
        i  = ii;
        d  = dd;
        ci = cc;
        cn = nn;
        #1;
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        rst_ = 1'b0; oe_ = 1'b1; i = FPC; d = '0; cn = 1'b0; ci = 1'b0;

        // Reset state with output disabled
        tick();
        chk("rst_pc", 8'(dut.pc), 8'h0);
        chk("rst_sp", 8'(dut.sp), 8'h0);
        chk("rst_empty_", 8'(empty_), 8'h0);
        chk("rst_full_", 8'(full_), 8'h1);
        chk("rst_ovf", 8'(ovf), 8'h0);
        chk("rst_udf", 8'(udf), 8'h0);
        chk("rst_y_float", 8'(dut.yen), 8'h0);

        rst_ = 1'b1; oe_ = 1'b0;

        // PRST, PLDR, FPC, FR, FPR, FPLR sequence
        drive(PRST, 4'h0, 1'b1, 1'b0); chk("prst_y", 8'(y), 8'h0); tick();
        drive(PLDR, 4'hA, 1'b1, 1'b0); chk("pldr_y", 8'(y), 8'h0); tick();
        drive(FPC,  4'h0, 1'b1, 1'b0); chk("fpc_y",  8'(y), 8'h1); tick();
        drive(FR,   4'h0, 1'b1, 1'b0); chk("fr_y",   8'(y), 8'hA); tick();
        drive(FPR,  4'h0, 1'b1, 1'b0); chk("fpr_y",  8'(y), 8'hD); tick();
        drive(FPLR, 4'h0, 1'b1, 1'b0); chk("fplr_y", 8'(y), 8'h4); tick();
        chk("seq_r", 8'(dut.r), 8'h4);
        chk("seq_pc", 8'(dut.pc), 8'h5);

        // Set r=0101, pc=1010, then call pc+r and return
        drive(PLDR, 4'h5, 1'b0, 1'b0); tick();
        drive(JMPD, 4'hA, 1'b0, 1'b0); chk("jmpd_y", 8'(y), 8'hA); tick();
        chk("jmpd_pc", 8'(dut.pc), 8'hA);
        drive(JSPR, 4'h0, 1'b0, 1'b0); chk("jspr_y", 8'(y), 8'hF); tick();
        chk("jspr_pc", 8'(dut.pc), 8'hF);
        chk("jspr_sp", 8'(dut.sp), 8'h1);
        chk("jspr_stk0", 8'(dut.u_stack.stk[0]), 8'hA);
        chk("jspr_cn4", 8'(cn4), 8'h1);
        drive(RTS, 4'h0, 1'b1, 1'b0); chk("rts_y", 8'(y), 8'hA); tick();
        chk("rts_pc", 8'(dut.pc), 8'hB);
        chk("rts_sp", 8'(dut.sp), 8'h0);

        // Fill the stack: 17 pushes of d=(k+3) mod 16
        for (int k = 0; k < DEPTH; k++) begin
            v = 4'(k + 3);
            drive(PSHD, v, 1'b0, 1'b0);
            chk("pshd_y", 8'(y), 8'hB);
            tick();
        end
        chk("fill_sp", 8'(dut.sp), 8'd17);
        chk("fill_full_", 8'(full_), 8'h0);
        chk("fill_ovf", 8'(ovf), 8'h0);
        drive(PSHD, 4'hF, 1'b0, 1'b0); tick();
        chk("over_sp", 8'(dut.sp), 8'd17);
        chk("over_ovf", 8'(ovf), 8'h1);
        drive(POPS, 4'h0, 1'b0, 1'b0); chk("pop_top_y", 8'(y), 8'h3); tick();
        chk("pop_sp", 8'(dut.sp), 8'd16);
        chk("pop_full_", 8'(full_), 8'h1);
        chk("pop_ovf_sticky", 8'(ovf), 8'h1);

        // Drain in LIFO order
        for (int k = 15; k >= 0; k--) begin
            v = 4'(k + 3);
            drive(POPS, 4'h0, 1'b0, 1'b0);
            chk("drain_y", 8'(y), 8'(v));
            tick();
        end
        chk("drain_empty_", 8'(empty_), 8'h0);

        // Pop from empty: y shows word 0, underflow latches
        drive(POPS, 4'h0, 1'b0, 1'b0); chk("udf_y", 8'(y), 8'h3); tick();
        chk("udf_flag", 8'(udf), 8'h1);
        chk("udf_sp", 8'(dut.sp), 8'h0);
        drive(PRST, 4'h0, 1'b0, 1'b0); tick();
        chk("prst_ovf", 8'(ovf), 8'h0);
        chk("prst_udf", 8'(udf), 8'h0);

        // Suspend, carries while floating, incrementer wrap
        drive(JMPD, 4'hE, 1'b1, 1'b0); tick();
        chk("jmpd_ci_pc", 8'(dut.pc), 8'hF);
        drive(PSUS, 4'h0, 1'b1, 1'b0);
        chk("psus_y_float", 8'(dut.yen), 8'h0);
        chk("psus_cn4", 8'(cn4), 8'h1);
        tick();
        chk("psus_pc_held", 8'(dut.pc), 8'hF);
        drive(FPC, 4'h0, 1'b1, 1'b0); chk("wrap_ci4", 8'(ci4), 8'h1); tick();
        chk("wrap_pc", 8'(dut.pc), 8'h0);

        // Reset beats a jump in the same cycle
        drive(JMPD, 4'h6, 1'b0, 1'b0); tick();
        chk("jmpd_pc6", 8'(dut.pc), 8'h6);
        rst_ = 1'b0;
        drive(JMPD, 4'h9, 1'b0, 1'b0); tick();
        chk("rst_vs_jmpd_pc", 8'(dut.pc), 8'h0);
        rst_ = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/am2932_pcu.md
Name: am2932_pcu

Overview:
- Parametrised program control unit: next generation of the 4-bit am2932 slice.
- Generates microprogram/program addresses from a program counter (PC), an auxiliary register (R), a data input (D) and a LIFO stack.
- WIDTH and stack DEPTH are configurable. Adds empty flag, sticky overflow/underflow flags and a synchronous reset port.
- Cascadable through adder carry (cn/cn4) and incrementer carry (ci/ci4).

Parameters:
- WIDTH, 4: address/data width of PC, R, D, Y and stack entries.
- DEPTH, 17: number of stack words; sp ranges 0..DEPTH.
- SPW, $clog2(DEPTH+1): stack pointer width (derived, not overridden).

Ports:
- cp  in  1  clock, rising edge active.
- rst_  in  1  reset, synchronous, active-low.
- i  in  4  instruction code.
- d  in  WIDTH  data input.
- oe_  in  1  output enable, active-low.
- cn  in  1  carry-in of PC+R adder.
- ci  in  1  carry-in of incrementer.
- y  out  WIDTH  address output, tristate.
- cn4  out  1  adder carry-out.
- ci4  out  1  incrementer carry-out.
- full_  out  1  low when sp==DEPTH.
- empty_  out  1  low when sp==0.
- ovf  out  1  sticky stack overflow.
- udf  out  1  sticky stack underflow.

Behaviour:
- Internal state: pc[WIDTH], r[WIDTH], sp[SPW], stk[DEPTH][WIDTH], ovf, udf.
- Reset: rst_=0 at a cp edge sets pc=0, sp=0, ovf=0, udf=0. r and stk are not reset. rst_ overrides any instruction in the same cycle.
- Combinational terms:
  - sum = pc+r+cn.
  - cn4 = carry out of sum.
  - yint = source selected by instruction.
  - ci4 = carry out of yint+ci.
  - top = stk[sp-1] (stk[0] when sp==0).
- y = yint when oe_=0 and i!=PSUS, otherwise Z. Carries remain valid while y is tristated.
- Instructions (yint / effect at cp rise). Default next pc = pc+ci (wrap mod 2^WIDTH).
  - 0000 PRST: yint=0; pc=0, sp=0, ovf=0, udf=0.
  - 0001 PSUS: y=Z; all state held, including pc.
  - 0010 PSHD: yint=pc; push d.
  - 0011 POPS: yint=top; pop.
  - 0100 FPC: yint=pc.
  - 0101 JMPD: yint=d; pc=d+ci.
  - 0110 PSHP: yint=pc; push pc.
  - 0111 RTS: yint=top; pop; pc=top+ci.
  - 1000 FR: yint=r.
  - 1001 FPR: yint=sum.
  - 1010 FPLR: yint=pc; r=pc.
  - 1011 JMPR: yint=r; pc=r+ci.
  - 1100 JPPR: yint=sum; pc=sum+ci.
  - 1101 JSBR: yint=r; push pc; pc=r+ci.
  - 1110 JSPR: yint=sum; push pc; pc=sum+ci.
  - 1111 PLDR: yint=pc; r=d.
- Push: stk[sp]=value, sp=sp+1.
- Push when sp==DEPTH: stack words and sp unchanged, ovf=1. The pc update still occurs.
- Pop: sp=sp-1.
- Pop when sp==0: sp stays 0, udf=1, yint=stk[0].
- The pushed pc value is the pre-edge pc.
- Flags full_ and empty_ are combinational from the registered sp, so they update after the edge.
- ovf/udf stay set until PRST or rst_.
- Unknown (X) instruction: no requirement.

Decomposition:
- Package am2932_pcu_pkg holds the 16 instruction code localparams (PRST..PLDR).
- One sub-module, am2932_pcu_stack: DEPTH×WIDTH LIFO with sp, push/pop, top, full/empty, ovf/udf.

Test Plan (WIDTH=4, DEPTH=17):
- rst_=0, i=FPC → after edge pc=0000, sp=0, empty_=0, full_=1, ovf=udf=0. With oe_=1, y=ZZZZ.
- PRST, PLDR d=1010 ci=1, FPC, FR, FPR cn=0, FPLR → y sequence 0000, 0000, 0001, 1010, 1101, 0100. Final r=0100, pc=0101.
- With r=0101, pc=1010, JSPR cn=0 ci=0 → y=1111, pc=1111, sp=1, stk[0]=1010. After the edge cn4=1 (1111+0101). RTS ci=1 → y=1010, pc=1011, sp=0.
- 17 PSHD from empty → full_=0 at sp=17. 18th PSHD → sp stays 17, ovf=1. POPS → y=last pushed d, sp=16, full_=1, ovf stays 1.
- POPS at sp=0 → udf=1, sp=0. PRST → ovf=udf=0.
- PSUS → y=ZZZZ, pc held. pc=1111 with FPC ci=1 → ci4=1, pc wraps to 0000. rst_=0 coinciding with JMPD d=0110 → pc=0000.
